// File: rtl/fifo_uart_tx_drain.sv
// FIFO-draining UART transmitter: pops one word per frame and sends start, data LSB-first, [parity], stop.
// Optional even-parity bit is compiled in with `define FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_wr_en_mon,
  input  logic [DATA_WIDTH-1:0] fifo_d_out,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("fifo_uart_tx_drain: CLKS_PER_BIT must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state;
  logic [BAUD_W-1:0]     baud;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  assign fifo_rd_en = (state == REQ);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
      baud       <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          baud <= '0;
          if (enable && !fifo_empty) state <= REQ;
        end
        // The FIFO drops a read in any cycle it writes, so hold the request until it lands.
        REQ: begin
          baud <= '0;
          if (fifo_empty)           state <= IDLE;
          else if (!fifo_wr_en_mon) state <= WAIT;
        end
        WAIT: begin
          shift_reg  <= fifo_d_out;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_bit <= ^fifo_d_out;
`endif
          tx         <= 1'b0;
          baud       <= '0;
          state      <= START;
        end
        // The next bit is always shift_reg[0]; it is shifted out as it is driven onto tx.
        START: begin
          if (baud == BAUD_LAST) begin
            baud      <= '0;
            bit_cnt   <= '0;
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_cnt == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            tx_done <= 1'b1;
            state   <= (enable && !fifo_empty) ? REQ : IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
